sram_ctrl: RTL and testbench
============================

# sram_ctrl

Sequences 32-bit data-memory accesses of the MEM stage onto an external 16-bit asynchronous SRAM as two half-word phases. While an access is in flight it holds `ready` low; the top level drives the pipeline `freeze` (IF/ID and the pipeline registers) from `~ready`. The pipeline therefore stalls on every load or store and resumes when the controller signals completion.

## Interface
- `WAIT_CYCLES`, default 2: extra cycles per half-word phase; only used with `SRAM_WAIT_EN`.
- `BASE_ADDR`, default 1024: data-memory base subtracted from the CPU address.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  store request from MEM stage.
- `rd_en`  in  1  load request from MEM stage.
- `address`  in  32  CPU byte address.
- `writeData`  in  32  store data.
- `readData`  out  32  load data; valid from the DONE cycle and held until the next load completes.
- `ready`  out  1  high when the controller is not stalling the pipeline.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  SRAM strobes, active low.

## Operation
- Physical address: `pa = address - BASE_ADDR`, taken mod 2^32.
- Word index: `w = pa[18:2]`. Low half-word goes to SRAM address `{w,1'b0}`, high half-word to `{w,1'b1}`.
- States: IDLE, LO, HI, DONE.
- IDLE, no request: `ready=1` and the controller stays in IDLE.
- IDLE, with `rd_en|wr_en`:
  - `ready=0`.
  - On the clock edge, latch `w`, `writeData` and the operation, then go to LO.
  - If both enables are high, the write wins.
- LO: drive `SRAM_ADDR={w,0}`.
  - Write: `SRAM_WE_N=0` and `SRAM_DQ=wdata[15:0]`.
  - Read: `SRAM_WE_N=1`, `SRAM_DQ` high-Z, and capture `SRAM_DQ` into `rdata[15:0]` on the phase's last edge.
  - Next state: HI.
- HI: same as LO with `{w,1}` and bits [31:16]. Next state: DONE.
- DONE: `ready=1` and `SRAM_WE_N=1`. Next state is IDLE unconditionally; a new request is recognised there.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N` and `SRAM_LB_N` are tied to 0.
- `SRAM_DQ` is driven only during LO/HI of a write.
- `rd_en`/`wr_en` are ignored once the controller leaves IDLE; the latched operation always completes.
- Outputs after reset:
  - `state=IDLE`, `readData=0`, latched address/data = 0.
  - `SRAM_ADDR=0`, `SRAM_WE_N=1`, `SRAM_DQ` high-Z.
  - `ready` follows the IDLE rule.

## Timing
- Base latency: a request first seen in cycle 0 gives `ready=0` in cycles 0–2 and `ready=1` in cycle 3 (DONE). That is 3 stall cycles per access.
- `readData` updates at the HI→DONE edge and is stable throughout DONE. The upper half of `readData` is never stale during DONE.
- Back-to-back requests: DONE (ready=1) → IDLE (ready=0 if a request is present). The minimum request-to-request spacing is 4 cycles.
- Reset asserted mid-access: immediate return to IDLE with `SRAM_WE_N=1` and DQ released, asynchronously and with no clock needed. The partial write is lost and `readData` clears to 0.
- `ready` is combinational from the state and the request inputs; every other output is a function of registered state only.

## Configuration
- `SRAM_WAIT_EN` defined:
  - Each of LO and HI lasts `1+WAIT_CYCLES` cycles, counted by a phase counter that is cleared on each phase entry.
  - Address, WE_N and DQ are held stable for the whole phase; read data is captured on the phase's last edge.
  - Stall is `1+2*(1+WAIT_CYCLES)` cycles, which is 7 at the default.
- `SRAM_WAIT_EN` undefined: `WAIT_CYCLES` is ignored, no counter is built, and phases are one cycle each.

## Test plan
- Store 0xDEADBEEF to address 1024+8 →
  - LO: `SRAM_ADDR=4`, `DQ=0xBEEF`, `WE_N=0`.
  - HI: `SRAM_ADDR=5`, `DQ=0xDEAD`.
  - `ready` is low for exactly 3 cycles, then high.
- Load from 1024+8 with the SRAM model holding 0xBEEF/0xDEAD → `readData=0xDEADBEEF` in DONE, held through later idle cycles.
- `rd_en` and `wr_en` both high with data 0x12345678 → a write is performed and `readData` is unchanged.
- Request dropped after cycle 0 → the access still completes and `ready` rises in cycle 3.
- `rst` pulsed during HI of a write → `WE_N=1` and DQ high-Z in the same cycle, `state=IDLE`, `readData=0`.
- `SRAM_WAIT_EN` defined, `WAIT_CYCLES=2`, load → `ready` low for 7 cycles; `SRAM_ADDR` is stable for 3 cycles per phase.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit MEM-stage accesses onto a 16-bit async SRAM in two phases.
// Optional macro SRAM_WAIT_EN stretches each phase to 1+WAIT_CYCLES cycles.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic [15:0] rlo_q;
    logic [31:0] rdata_q;
    logic [17:0] addr_q;
    logic        we_n_q;
    logic        dq_oe_q;
    logic [15:0] dq_q;

    logic [31:0] pa;
    logic        req;
    logic        last;

    assign pa  = address - 32'(BASE_ADDR);
    assign req = rd_en | wr_en;

`ifdef SRAM_WAIT_EN
    logic [7:0] cnt_q;

    assign last = (cnt_q == 8'(WAIT_CYCLES));

    // Phase counter: counts inside LO/HI, zero on every phase entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == LO || state_q == HI) && !last) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_wait;

    assign last        = 1'b1;
    assign unused_wait = |WAIT_CYCLES;
`endif

    logic unused_pa;
    assign unused_pa = ^{pa[31:19], pa[1:0]};

    // Access sequencer with registered SRAM strobes, address and data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rlo_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            dq_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= LO;
                        word_q  <= pa[18:2];
                        wdata_q <= writeData;
                        wr_q    <= wr_en;
                        addr_q  <= {pa[18:2], 1'b0};
                        we_n_q  <= ~wr_en;
                        dq_oe_q <= wr_en;
                        dq_q    <= writeData[15:0];
                    end
                end
                LO: begin
                    if (last) begin
                        state_q <= HI;
                        if (!wr_q) rlo_q <= SRAM_DQ;
                        addr_q  <= {word_q, 1'b1};
                        dq_q    <= wdata_q[31:16];
                    end
                end
                HI: begin
                    if (last) begin
                        state_q <= DONE;
                        if (!wr_q) rdata_q <= {SRAM_DQ, rlo_q};
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = (state_q == IDLE) ? ~req : (state_q == DONE);

    assign readData  = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_q : 16'bz;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed accesses against an SRAM model, checked by a
// scoreboard monitor that fires whenever an access completes (ready rises).
module tb_sram_ctrl;

`ifdef SRAM_WAIT_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif
    localparam int S = 1 + 2 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [17:0] lo;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    sram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];

    initial foreach (mem[i]) mem[i] = 16'h0;

    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[7:0]] : 16'bz;

    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    int   stall  = 0;
    logic bus_ok = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        logic hi;
        if (rst) begin
            stall  = 0;
            bus_ok = 1'b1;
        end else if (!ready) begin
            if (sb.size() == 0) begin
                bus_ok = 1'b0;
            end else if (stall >= 1 && stall <= 2 * P) begin
                e  = sb[0];
                hi = (stall > P);
                if (SRAM_ADDR !== {e.lo[17:1], hi}) bus_ok = 1'b0;
                if (SRAM_WE_N !== !e.wr) bus_ok = 1'b0;
                if (e.wr && SRAM_DQ !== (hi ? e.wd[31:16] : e.wd[15:0]))
                    bus_ok = 1'b0;
            end
            stall++;
        end else if (stall > 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_access", 32'(stall), 32'd0);
            end else begin
                e = sb.pop_front();
                if (SRAM_WE_N !== 1'b1) bus_ok = 1'b0;
                chk("stall_cycles", 32'(stall), 32'(S));
                chk("sram_bus", {31'd0, bus_ok}, 32'd1);
                chk("readData_done", readData, e.rd);
            end
            stall  = 0;
            bus_ok = 1'b1;
        end
    end

    task automatic issue(input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [17:0] lo, input logic [31:0] rdx);
        exp_t e;
        e.wr = we;
        e.lo = lo;
        e.wd = d;
        e.rd = rdx;
        sb.push_back(e);
        wr_en     = we;
        rd_en     = re;
        address   = a;
        writeData = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (S) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        address   = '0;
        writeData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readData", readData, 32'h0);
        chk("rst_addr", {14'd0, SRAM_ADDR}, 32'h0);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'h1);
        chk("rst_dq_drive", {31'd0, dut.dq_oe_q}, 32'h0);
        chk("tied_strobes",
            {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'd0, ready}, 32'h1);
        @(posedge clk);
        #1;

        issue(1, 0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
        issue(0, 1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        chk("readData_hold", readData, 32'hDEADBEEF);
        issue(1, 1, 32'd1036, 32'h12345678, 18'd6, 32'hDEADBEEF);
        issue(0, 1, 32'd1036, 32'h0, 18'd6, 32'h12345678);
        issue(1, 0, 32'd1280, 32'hCAFEF00D, 18'd128, 32'h12345678);
        issue(0, 1, 32'd1280, 32'h0, 18'd128, 32'hCAFEF00D);
        issue(1, 0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 32'hCAFEF00D);
        issue(0, 1, 32'd1020, 32'h0, 18'h3FFFE, 32'hA5A55A5A);

        wr_en     = 1'b1;
        address   = 32'd1032;
        writeData = 32'h11112222;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        repeat (P) @(posedge clk);
        #1;
        chk("hi_write_active", {31'd0, SRAM_WE_N}, 32'h0);
        rst = 1'b1;
        #1;
        chk("abort_we_n", {31'd0, SRAM_WE_N}, 32'h1);
        chk("abort_dq_drive", {31'd0, dut.dq_oe_q}, 32'h0);
        chk("abort_readData", readData, 32'h0);
        chk("abort_ready", {31'd0, ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 1, 32'd1032, 32'h0, 18'd4, 32'hDEAD2222);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_accesses", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
